wb_timer: RTL
=============

# wb_timer

Wishbone slave timer peripheral for the Muskoka SoC: a 32-bit programmable down-counter with auto-reload, an expiry flag and a level interrupt. It sits behind `wb_intercon` as a responder to the moxie core's bus accesses. It implements the slave side of the same 32-bit data / 16-bit-granule Wishbone interface the core drives.

## Interface
- `RESET_LOAD`, default 32'h0000_0000: reset value of LOAD and COUNT.
- `rst_i`  in  1  asynchronous, active-high reset.
- `clk_i`  in  1  single clock; all state is on the rising edge.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, registered.
- `wb_adr_i`  in  31 ([31:1])  address; `wb_adr_i[3:2]` selects the register; other bits are ignored.
- `wb_sel_i`  in  2  byte-lane select: `[1]` enables bits 31:16, `[0]` enables bits 15:0.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_ack_o`  out  1  acknowledge, one-cycle pulse.
- `irq_o`  out  1  interrupt request, level, active-high.

## Operation
- Registers, selected by index `wb_adr_i[3:2]`:
  - 0 CTRL: bit0 EN, bit1 RELOAD, bit2 IE, bits[15:8] PSC. All other bits read 0. Reset value 0.
  - 1 LOAD: reload value, R/W. Reset value `RESET_LOAD`.
  - 2 COUNT: live counter. A write sets the counter directly. Reset value `RESET_LOAD`.
  - 3 STATUS: bit0 EXP. Writing 1 clears EXP; writing 0 has no effect. Reset value 0.
- Writes are lane-masked by `wb_sel_i`; unselected halves keep their value.
- A tick occurs when EN=1 and the prescaler matures (see Configuration).
- Tick with COUNT≠0: COUNT decrements by 1.
- Tick with COUNT=0:
  - EXP is set to 1.
  - If RELOAD=1, COUNT is loaded with LOAD.
  - If RELOAD=0, COUNT stays at 0 and EN clears to 0 (one-shot).
- Expiry period with RELOAD=1 is LOAD+1 ticks.
- `irq_o` = EXP & IE, combinational from registered state.
- Simultaneous events in the same cycle:
  - Bus write to COUNT and a tick: the write wins.
  - Bus write to CTRL and a one-shot EN clear: the written EN value wins.
  - STATUS clear and a new expiry: the set wins, so EXP stays 1.

## Timing
- A request is accepted when `wb_cyc_i & wb_stb_i & ~wb_ack_o` is high at a rising edge.
- On that edge:
  - `wb_ack_o` rises and stays high for exactly one cycle.
  - Write data commits to the register.
  - For reads, `wb_dat_o` captures the register's pre-edge value and holds it until the next accepted read.
- Latency is 1 cycle from request to ack.
- Maximum throughput is one access per 2 cycles. With `wb_stb_i` held high, ack toggles 1,0,1,0.
- Dropping `wb_stb_i` or `wb_cyc_i` before the ack edge cancels the request with no side effects.
- Reset: `rst_i` high immediately forces all of the following, regardless of the clock:
  - `wb_ack_o`=0, `wb_dat_o`=0, `irq_o`=0.
  - CTRL=0, STATUS=0, prescaler=0.
  - LOAD and COUNT = `RESET_LOAD`.
  - An in-flight access is dropped with no ack.

## Configuration
- `MUSKOKA_TIMER_PRESCALER_EN` defined:
  - An 8-bit prescaler counts clocks while EN=1.
  - A tick fires when the prescaler equals PSC, and the prescaler then returns to 0. A tick therefore occurs every PSC+1 clocks.
  - The prescaler is held at 0 while EN=0 and is cleared on any CTRL write.
- Not defined:
  - No prescaler logic is built.
  - CTRL[15:8] reads 0 and writes to it are ignored.
  - A tick occurs every clock while EN=1.

## Test plan
- Reset with `RESET_LOAD`=5, then read all four registers -> CTRL=0, LOAD=5, COUNT=5, STATUS=0; each ack is exactly 1 cycle wide.
- Write LOAD=3, then CTRL=0x7 (EN, RELOAD, IE), with PSC=0 -> EXP and `irq_o` rise after 4 ticks; COUNT sequence is 3,2,1,0,3,…; `irq_o` stays high until STATUS is written with 1.
- One-shot: COUNT=2, CTRL=0x1 -> EXP=1 after 3 ticks, COUNT holds at 0, CTRL reads 0; `irq_o` stays 0 because IE=0.
- Lane write: write 0xAAAA_BBBB to LOAD with `wb_sel_i`=2'b01 over LOAD=0x1111_2222 -> LOAD reads 0x1111_BBBB.
- Collisions:
  - STATUS clear on the same edge as an expiry -> EXP remains 1.
  - COUNT write of 9 on the same edge as a tick -> COUNT=9.
- With the macro, PSC=3 and LOAD=1, RELOAD=1 -> EXP is set 8 clocks after EN. Without the macro, the same setup sets EXP after 2 clocks and CTRL reads back with bits[15:8]=0.
- Assert `rst_i` mid-ack and mid-count -> all outputs are 0 in the same cycle and no ack follows the deassertion of reset.

Source files
------------

// File: rtl/wb_timer_if.sv
// Wishbone bus bundle for the wb_timer peripheral: 32-bit data, 16-bit lane granularity.
// Signal names are as seen from the slave side.
interface wb_timer_if;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [31:1] wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_timer.sv
// Wishbone slave 32-bit down-counter with auto-reload, expiry flag and level interrupt.
// Define MUSKOKA_TIMER_PRESCALER_EN to build the 8-bit tick prescaler (CTRL[15:8] = PSC).
module wb_timer #(
  parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_timer_if.slave   wb,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    RegCtrl   = 2'd0,
    RegLoad   = 2'd1,
    RegCount  = 2'd2,
    RegStatus = 2'd3
  } reg_idx_e;

  reg_idx_e    idx;
  logic        req;
  logic        wr;
  logic        rd;
  logic [31:0] wmask;
  logic [31:0] rd_val;
  logic        tick;
  logic        expire;
  logic        status_clr;
  logic [7:0]  psc_rd;
  logic        unused_adr;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        en_q, en_d;
  logic        reload_q, reload_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;

  // Holding ack for one cycle blocks re-acceptance, giving the 1,0,1,0 pattern.
  assign req   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr    = req & wb.wb_we_i;
  assign rd    = req & ~wb.wb_we_i;
  assign idx   = reg_idx_e'(wb.wb_adr_i[3:2]);
  assign wmask = {{16{wb.wb_sel_i[1]}}, {16{wb.wb_sel_i[0]}}};

  assign unused_adr = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1]};

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

`ifdef MUSKOKA_TIMER_PRESCALER_EN
  logic [7:0] psc_q, psc_d;
  logic [7:0] pre_q, pre_d;

  assign tick   = en_q && (pre_q == psc_q);
  assign psc_rd = psc_q;

  always_comb begin
    psc_d = psc_q;
    pre_d = pre_q;
    if (!en_q || tick) begin
      pre_d = 8'd0;
    end else begin
      pre_d = pre_q + 8'd1;
    end
    // Any CTRL write restarts the prescaler so a new PSC takes effect cleanly.
    if (wr && (idx == RegCtrl)) begin
      pre_d = 8'd0;
      if (wb.wb_sel_i[0]) begin
        psc_d = wb.wb_dat_i[15:8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_q <= 8'd0;
      pre_q <= 8'd0;
    end else begin
      psc_q <= psc_d;
      pre_q <= pre_d;
    end
  end
`else
  assign tick   = en_q;
  assign psc_rd = 8'd0;
`endif

  assign expire     = tick && (count_q == 32'd0);
  assign status_clr = wr && (idx == RegStatus) && wb.wb_sel_i[0] && wb.wb_dat_i[0];

  always_comb begin
    rd_val = 32'd0;
    unique case (idx)
      RegCtrl:   rd_val = {16'h0000, psc_rd, 5'b00000, ie_q, reload_q, en_q};
      RegLoad:   rd_val = load_q;
      RegCount:  rd_val = count_q;
      RegStatus: rd_val = {31'd0, exp_q};
    endcase
  end

  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    load_d   = load_q;
    count_d  = count_q;
    ack_d    = req;
    dat_d    = dat_q;

    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (reload_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // Expiry set has priority over a same-cycle clear.
    exp_d = expire | (exp_q & ~status_clr);

    // Bus writes are applied last so they override the timer's own update.
    if (wr) begin
      unique case (idx)
        RegCtrl: begin
          if (wb.wb_sel_i[0]) begin
            en_d     = wb.wb_dat_i[0];
            reload_d = wb.wb_dat_i[1];
            ie_d     = wb.wb_dat_i[2];
          end
        end
        RegLoad:   load_d  = merge_lanes(load_q, wb.wb_dat_i, wmask);
        RegCount:  count_d = merge_lanes(count_q, wb.wb_dat_i, wmask);
        RegStatus: ;
      endcase
    end

    if (rd) begin
      dat_d = rd_val;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
      load_q   <= RESET_LOAD;
      count_q  <= RESET_LOAD;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
      load_q   <= load_d;
      count_q  <= count_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = exp_q & ie_q;

endmodule
